// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared colours, mode encoding and panel geometry for the TFT pattern source
package tft_pkg;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_GRID   = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_e;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/tft_square_mover.sv
// rtl/tft_square_mover.sv - bouncing square position, advanced once per frame tick
module tft_square_mover
  import tft_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned SQ_SIZE  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SQ_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - SQ_SIZE);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dx_pos_q, dx_pos_d, dy_pos_q, dy_pos_d;

  // At a wall the direction flips and the step is taken in the new direction on the same tick.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    if (tick) begin
      if (dx_pos_q) begin
        if (x_q == X_MAX) begin
          dx_pos_d = 1'b0;
          x_d      = x_q - 10'd1;
        end else begin
          x_d      = x_q + 10'd1;
        end
      end else begin
        if (x_q == 10'd0) begin
          dx_pos_d = 1'b1;
          x_d      = x_q + 10'd1;
        end else begin
          x_d      = x_q - 10'd1;
        end
      end
      if (dy_pos_q) begin
        if (y_q == Y_MAX) begin
          dy_pos_d = 1'b0;
          y_d      = y_q - 10'd1;
        end else begin
          y_d      = y_q + 10'd1;
        end
      end else begin
        if (y_q == 10'd0) begin
          dy_pos_d = 1'b1;
          y_d      = y_q + 10'd1;
        end else begin
          y_d      = y_q - 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      dx_pos_q <= 1'b1;
      dy_pos_q <= 1'b1;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      dx_pos_q <= dx_pos_d;
      dy_pos_q <= dy_pos_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/tft_pattern_gen.sv
// rtl/tft_pattern_gen.sv - four-pattern RGB565 test source for TFT_CTRL; TFT_PATTERN_CROSSHAIR_EN adds a centre crosshair
module tft_pattern_gen
  import tft_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned SQ_SIZE    = 64,
  parameter int unsigned GRID_STEP  = 32,
  parameter int unsigned COLOR_HOLD = 64
) (
  input  logic        Clk33M,
  input  logic        Rst,
  input  logic [9:0]  Hcount,
  input  logic [9:0]  Vcount,
  input  logic        Mode_key,
  output logic [15:0] Data_out,
  output logic [1:0]  Mode,
  output logic        Frame_tick
);

  localparam int unsigned GRID_BITS = $clog2(GRID_STEP);
  localparam int unsigned CNT_MAX   = 4 * COLOR_HOLD;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);
  localparam int unsigned BAR_W     = H_ACTIVE / 8;

  logic [9:0]       vcount_d_q;
  logic [1:0]       pending_q, pending_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [15:0]      data_q, data_d;
  logic             frame_tick_q;
  logic             tick_c;
  logic [9:0]       sq_x, sq_y;
  logic [2:0]       bar_idx;
  logic             in_sq;

  tft_square_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .SQ_SIZE  (SQ_SIZE)
  ) u_mover (
    .clk  (Clk33M),
    .rst  (Rst),
    .tick (tick_c),
    .x    (sq_x),
    .y    (sq_y)
  );

  // The tick pixel already shows the new mode but still uses the old position and counter.
  always_comb begin
    tick_c      = (vcount_d_q != 10'd0) && (Vcount == 10'd0);
    pending_d   = pending_q + 2'(Mode_key);
    mode_d      = tick_c ? mode_e'(pending_d) : mode_q;
    frame_cnt_d = frame_cnt_q;
    if (tick_c) begin
      frame_cnt_d = (frame_cnt_q == CNT_W'(CNT_MAX - 1)) ? '0 : frame_cnt_q + 1'b1;
    end

    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (Hcount >= 10'(i * BAR_W)) bar_idx = 3'(i);
    end

    in_sq = ({1'b0, Hcount} >= {1'b0, sq_x}) && ({1'b0, Hcount} < {1'b0, sq_x} + 11'(SQ_SIZE)) &&
            ({1'b0, Vcount} >= {1'b0, sq_y}) && ({1'b0, Vcount} < {1'b0, sq_y} + 11'(SQ_SIZE));

    case (mode_d)
      MODE_BARS:   data_d = bar_color(bar_idx);
      MODE_GRID:   data_d = (Hcount[GRID_BITS-1:0] == '0 || Vcount[GRID_BITS-1:0] == '0) ? C_WHITE : C_BLACK;
      MODE_SQUARE: data_d = in_sq ? C_RED : C_BLUE;
      default: begin
        if (frame_cnt_q < CNT_W'(COLOR_HOLD))          data_d = C_RED;
        else if (frame_cnt_q < CNT_W'(2 * COLOR_HOLD)) data_d = C_GREEN;
        else if (frame_cnt_q < CNT_W'(3 * COLOR_HOLD)) data_d = C_BLUE;
        else                                           data_d = C_WHITE;
      end
    endcase

`ifdef TFT_PATTERN_CROSSHAIR_EN
    if (Hcount == 10'(H_ACTIVE / 2) || Vcount == 10'(V_ACTIVE / 2)) begin
      data_d = (mode_d == MODE_SOLID) ? C_GREEN : C_RED;
    end
`endif

    if (Hcount >= 10'(H_ACTIVE) || Vcount >= 10'(V_ACTIVE)) data_d = C_BLACK;
  end

  always_ff @(posedge Clk33M) begin
    if (Rst) begin
      vcount_d_q   <= 10'd0;
      pending_q    <= 2'd0;
      mode_q       <= MODE_BARS;
      frame_cnt_q  <= '0;
      data_q       <= C_BLACK;
      frame_tick_q <= 1'b0;
    end else begin
      vcount_d_q   <= Vcount;
      pending_q    <= pending_d;
      mode_q       <= mode_d;
      frame_cnt_q  <= frame_cnt_d;
      data_q       <= data_d;
      frame_tick_q <= tick_c;
    end
  end

  assign Data_out   = data_q;
  assign Mode       = mode_q;
  assign Frame_tick = frame_tick_q;

endmodule

// File: tb/tb_tft_pattern_gen.sv
// tb/tb_tft_pattern_gen.sv - randomized and directed checks of tft_pattern_gen against a frame-level model
module tb_tft_pattern_gen;

  logic        Clk33M = 1'b0;
  logic        Rst;
  logic [9:0]  Hcount, Vcount;
  logic        Mode_key;
  logic [15:0] Data_out;
  logic [1:0]  Mode;
  logic        Frame_tick;

  always #15 Clk33M = ~Clk33M;

  tft_pattern_gen dut (
    .Clk33M     (Clk33M),
    .Rst        (Rst),
    .Hcount     (Hcount),
    .Vcount     (Vcount),
    .Mode_key   (Mode_key),
    .Data_out   (Data_out),
    .Mode       (Mode),
    .Frame_tick (Frame_tick)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: frame-level quantities only.
  int m_pend, m_mode, m_x, m_y, m_dx, m_dy, m_cnt, m_vd;
  logic [15:0] bar_tab [8];
  logic [15:0] solid_tab [4];

  function automatic logic [15:0] model_pixel(int md, int h, int v);
    if (h >= 800 || v >= 480) return 16'h0000;
`ifdef TFT_PATTERN_CROSSHAIR_EN
    if (h == 400 || v == 240) return (md == 3) ? 16'h07E0 : 16'hF800;
`endif
    case (md)
      0:       return bar_tab[h / 100];
      1:       return (h % 32 == 0 || v % 32 == 0) ? 16'hFFFF : 16'h0000;
      2:       return (h >= m_x && h < m_x + 64 && v >= m_y && v < m_y + 64) ? 16'hF800 : 16'h001F;
      default: return solid_tab[m_cnt / 64];
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_mode = 0; m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_cnt = 0; m_vd = 0;
  endtask

  task automatic cyc(input int h, input int v, input bit k, input bit r);
    logic [15:0] e_data;
    int          e_mode;
    bit          tick;
    int          nx, ny;
    Hcount   = 10'(h);
    Vcount   = 10'(v);
    Mode_key = k;
    Rst      = r;
    if (r) begin
      model_reset();
      e_data = 16'h0000; e_mode = 0; tick = 1'b0;
    end else begin
      tick   = (m_vd != 0) && (v == 0);
      m_pend = (m_pend + (k ? 1 : 0)) % 4;
      if (tick) m_mode = m_pend;
      e_mode = m_mode;
      e_data = model_pixel(m_mode, h, v);
      if (tick) begin
        nx = m_x + m_dx;
        if (nx < 0 || nx > 736) begin m_dx = -m_dx; nx = m_x + m_dx; end
        ny = m_y + m_dy;
        if (ny < 0 || ny > 416) begin m_dy = -m_dy; ny = m_y + m_dy; end
        m_x = nx; m_y = ny;
        m_cnt = (m_cnt + 1) % 256;
      end
      m_vd = v;
    end
    @(posedge Clk33M);
    #1;
    check("data", Data_out, e_data);
    check("mode", {14'd0, Mode}, 16'(e_mode));
    check("frame_tick", {15'd0, Frame_tick}, {15'd0, tick});
  endtask

  task automatic frame();
    cyc($urandom_range(0, 850), 1, 1'b0, 1'b0);
    cyc($urandom_range(0, 850), 0, 1'b0, 1'b0);
  endtask

  initial begin
    bar_tab   = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    solid_tab = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    Rst = 1'b1; Hcount = 10'd100; Vcount = 10'd100; Mode_key = 1'b0;
    model_reset();

    for (int i = 0; i < 5; i++) cyc(100, 100, 1'b0, 1'b1);

    cyc(0, 10, 1'b0, 1'b0);   check("bars_0", Data_out, 16'hFFFF);
    cyc(99, 10, 1'b0, 1'b0);  check("bars_99", Data_out, 16'hFFFF);
    cyc(100, 10, 1'b0, 1'b0); check("bars_100", Data_out, 16'hFFE0);
    cyc(450, 10, 1'b0, 1'b0); check("bars_450", Data_out, 16'hF81F);
    cyc(799, 10, 1'b0, 1'b0); check("bars_799", Data_out, 16'h0000);
    cyc(800, 10, 1'b0, 1'b0); check("bars_800", Data_out, 16'h0000);

    cyc(300, 200, 1'b1, 1'b0); check("sw_hold0", {14'd0, Mode}, 16'd0);
    cyc(300, 200, 1'b1, 1'b0);
    cyc(300, 479, 1'b0, 1'b0); check("sw_hold1", {14'd0, Mode}, 16'd0);
    cyc(0, 0, 1'b0, 1'b0);
    check("sw_mode2", {14'd0, Mode}, 16'd2);
    check("sw_pix", Data_out, 16'hF800);
    check("sw_tick", {15'd0, Frame_tick}, 16'd1);

    cyc(0, 0, 1'b0, 1'b1); cyc(0, 0, 1'b0, 1'b1);
    cyc(0, 5, 1'b1, 1'b0); cyc(0, 5, 1'b1, 1'b0);
    for (int n = 1; n <= 738; n++) begin
      frame();
      if (n == 416) begin
        cyc(416, 416, 1'b0, 1'b0); check("b416_in", Data_out, 16'hF800);
        cyc(416, 415, 1'b0, 1'b0); check("b416_above", Data_out, 16'h001F);
        cyc(415, 416, 1'b0, 1'b0); check("b416_left", Data_out, 16'h001F);
        cyc(479, 479, 1'b0, 1'b0); check("b416_corner", Data_out, 16'hF800);
      end
      if (n == 417) begin
        cyc(417, 415, 1'b0, 1'b0); check("b417_in", Data_out, 16'hF800);
        cyc(417, 414, 1'b0, 1'b0); check("b417_above", Data_out, 16'h001F);
        cyc(480, 478, 1'b0, 1'b0); check("b417_corner", Data_out, 16'hF800);
      end
      if (n == 738) begin
        cyc(734, 94, 1'b0, 1'b0);  check("b738_in", Data_out, 16'hF800);
        cyc(733, 94, 1'b0, 1'b0);  check("b738_left", Data_out, 16'h001F);
        cyc(797, 157, 1'b0, 1'b0); check("b738_corner", Data_out, 16'hF800);
        cyc(798, 94, 1'b0, 1'b0);  check("b738_right", Data_out, 16'h001F);
      end
    end

    cyc(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 5, 1'b1, 1'b0);
    for (int n = 1; n <= 257; n++) begin
      frame();
      cyc(10, 10, 1'b0, 1'b0);
      if (n == 1)   check("solid1", Data_out, 16'hF800);
      if (n == 63)  check("solid63", Data_out, 16'hF800);
      if (n == 64)  check("solid64", Data_out, 16'h07E0);
      if (n == 127) check("solid127", Data_out, 16'h07E0);
      if (n == 128) check("solid128", Data_out, 16'h001F);
      if (n == 192) check("solid192", Data_out, 16'hFFFF);
      if (n == 255) check("solid255", Data_out, 16'hFFFF);
      if (n == 256) check("solid256", Data_out, 16'hF800);
    end

    cyc(0, 0, 1'b0, 1'b1);
    cyc(0, 5, 1'b1, 1'b0);
    frame();
    cyc(400, 7, 1'b0, 1'b0);
`ifdef TFT_PATTERN_CROSSHAIR_EN
    check("xh_400", Data_out, 16'hF800);
`else
    check("grid_400", Data_out, 16'h0000);
`endif
    cyc(401, 7, 1'b0, 1'b0);  check("grid_401", Data_out, 16'h0000);
    cyc(64, 7, 1'b0, 1'b0);   check("grid_col", Data_out, 16'hFFFF);
    cyc(65, 32, 1'b0, 1'b0);  check("grid_row", Data_out, 16'hFFFF);
    cyc(65, 33, 1'b0, 1'b0);  check("grid_off", Data_out, 16'h0000);

    for (int i = 0; i < 4000; i++) begin
      int v;
      v = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 500);
      cyc($urandom_range(0, 850), v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 999) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
